// File: rtl/vq_decoder.sv
// ---------------------------------------------------------------------------
// vq_decoder
//
// Reconstruction side of the 8x8 VEP vector quantiser. The block holds a
// local 64-entry copy of the trained codebook. After a start pulse it walks
// the index RAM once, one pixel per cycle. For every pixel it looks up the
// codeword named by the stored winner tag and writes that codeword to the
// output image RAM. A single done pulse marks the end of the image.
//
// Parameters
//   N_PIX   pixels per image (>= 2)
//   AW      address width of the index and output RAMs (2**AW >= N_PIX)
//
// Ports
//   clk      positive-edge clock
//   rst      asynchronous active-high reset (also clears the codebook)
//   start    one-cycle start pulse, honoured only in IDLE
//   busy     high from the cycle after start is accepted until done
//   done     one-cycle pulse after the last output write
//   cb_we    codebook write enable (ignored unless IDLE)
//   cb_addr  codebook entry, tag = {y[2:0], x[2:0]}
//   cb_data  codeword {B[23:16], G[15:8], R[7:0]}
//   IDX_A    index RAM read address
//   IDX_Q    index RAM read data, valid one cycle after IDX_A
//   O_A      output RAM address
//   O_D      reconstructed pixel
//   O_WE     output RAM write enable
// ---------------------------------------------------------------------------
module vq_decoder #(
  parameter int N_PIX = 16384,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          cb_we,
  input  logic [5:0]    cb_addr,
  input  logic [23:0]   cb_data,
  output logic [AW-1:0] IDX_A,
  input  logic [5:0]    IDX_Q,
  output logic [AW-1:0] O_A,
  output logic [23:0]   O_D,
  output logic          O_WE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_PIX - 1);

  state_t        state;
  logic [23:0]   codebook [64];

  // Read side: rd_a is the address currently presented to the index RAM.
  // issue marks that rd_a has not yet been sampled by the RAM.
  logic [AW-1:0] rd_a;
  logic          issue;

  // v1/a1: IDX_Q holds valid data for address a1.
  logic          v1;
  logic [AW-1:0] a1;

  // Write stage registers, driven straight onto the output RAM port.
  logic          v2;
  logic [AW-1:0] o_a;
  logic [23:0]   o_d;

  // The codebook is writable only while idle, so the contents cannot change
  // under a running decode. A write in the same cycle as start still lands
  // before the first lookup, which happens two edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        codebook[i] <= 24'h000000;
      end
    end else if (cb_we && (state == S_IDLE)) begin
      codebook[cb_addr] <= cb_data;
    end
  end

  // Control FSM together with the three-stage pipeline: issue address, RAM
  // read, then lookup and write. DONE follows the edge that retires the
  // write of the last address. Using that condition, rather than a cycle
  // count, ties done to the actual final write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      rd_a  <= '0;
      issue <= 1'b0;
      v1    <= 1'b0;
      a1    <= '0;
      v2    <= 1'b0;
      o_a   <= '0;
      o_d   <= 24'h000000;
    end else begin
      v1  <= 1'b0;
      v2  <= v1;
      o_a <= a1;
      if (v1) begin
        o_d <= codebook[IDX_Q];
      end

      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            rd_a  <= '0;
            issue <= 1'b1;
          end
        end

        S_RUN: begin
          if (issue) begin
            v1 <= 1'b1;
            a1 <= rd_a;
            // The counter stops at the last address instead of wrapping.
            if (rd_a == LAST_ADDR) begin
              issue <= 1'b0;
            end else begin
              rd_a <= rd_a + 1'b1;
            end
          end
          if (v2 && (o_a == LAST_ADDR)) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          issue <= 1'b0;
        end
      endcase
    end
  end

  assign IDX_A = rd_a;
  assign O_A   = o_a;
  assign O_D   = o_d;
  assign O_WE  = v2;

endmodule
